// File: rtl/demux_striping_n.sv
// demux_striping_n
//
// Spreads a single stream of DATA_W-bit words over LANES output lanes.
// Each lane has a one-entry registered output stage with a valid/ready
// handshake, so the source is backpressured on a per-lane basis.
//
// The target lane comes from one of two places:
//   - round-robin (mode_rr = 1): an internal pointer that advances only when
//     a word is accepted;
//   - explicit select (mode_rr = 0): the selector port.
//
// Ports
//   clk_f      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   mode_rr    in   1 = round-robin striping, 0 = lane chosen by selector
//   selector   in   target lane when mode_rr = 0
//   data_in    in   input word
//   valid_in   in   data_in is valid
//   ready_out  out  word can be accepted this cycle (combinational, no
//                   dependency on valid_in)
//   data_out   out  lane i is bits [i*DATA_W +: DATA_W]
//   valid_out  out  lane i holds a word
//   ready_in   in   downstream of lane i accepts this cycle
//   lane_ptr   out  current round-robin pointer
//   err_sel    out  sticky: an out-of-range selector was presented with valid
//
// SEL_W must equal clog2(LANES), with a minimum of 1. LANES ranges from 2 to 8.
module demux_striping_n #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk_f,
   input  logic                    reset,
   input  logic                    mode_rr,
   input  logic [SEL_W-1:0]        selector,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic [LANES*DATA_W-1:0] data_out,
   output logic [LANES-1:0]        valid_out,
   input  logic [LANES-1:0]        ready_in,
   output logic [SEL_W-1:0]        lane_ptr,
   output logic                    err_sel
);

   logic [SEL_W-1:0] lane_ptr_reg;
   logic [SEL_W-1:0] lane_ptr_next;
   logic [SEL_W-1:0] target;
   logic [LANES-1:0] lane_free;
   logic [LANES-1:0] lane_load;
   logic             err_sel_reg;
   logic             in_range;
   logic             target_free;
   logic             accept;

   assign target = mode_rr ? lane_ptr_reg : selector;

   // The selector can encode lane numbers that do not exist when LANES is not
   // a power of two. The round-robin pointer always stays in range.
   assign in_range = {1'b0, target} < (SEL_W+1)'(LANES);

   // Looking up the target lane's free flag through a loop avoids indexing
   // past the end of lane_free when the selector is out of range.
   always_comb begin
      target_free = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (target == SEL_W'(i)) begin
            target_free = lane_free[i];
         end
      end
   end

   assign ready_out = !reset && in_range && target_free;
   assign accept    = valid_in && ready_out;

   // The pointer moves only on a round-robin accept. A stall therefore never
   // skips a lane, and strict lane order is preserved.
   always_comb begin
      lane_ptr_next = lane_ptr_reg;
      if (mode_rr && accept) begin
         lane_ptr_next = (lane_ptr_reg == SEL_W'(LANES - 1)) ? '0
                                                             : lane_ptr_reg + SEL_W'(1);
      end
   end

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         lane_ptr_reg <= '0;
         err_sel_reg  <= 1'b0;
      end else begin
         lane_ptr_reg <= lane_ptr_next;
         if (!mode_rr && valid_in && !in_range) begin
            err_sel_reg <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [DATA_W-1:0] lane_data_reg;
         logic              lane_valid_reg;

         // A lane is free when it is empty or is being drained this cycle.
         // Because of the second case, a lane can load and drain on the same
         // edge and keep up one word per cycle.
         assign lane_free[gi] = !lane_valid_reg || ready_in[gi];
         assign lane_load[gi] = accept && (target == SEL_W'(gi));

         always_ff @(posedge clk_f or posedge reset) begin
            if (reset) begin
               lane_data_reg  <= '0;
               lane_valid_reg <= 1'b0;
            end else if (lane_load[gi]) begin
               // If the lane also drains on this edge, the load takes
               // priority and valid stays high.
               lane_data_reg  <= data_in;
               lane_valid_reg <= 1'b1;
            end else if (lane_valid_reg && ready_in[gi]) begin
               // Data bits keep their last value. They are don't-care while
               // valid is low.
               lane_valid_reg <= 1'b0;
            end
         end

         assign data_out[gi*DATA_W +: DATA_W] = lane_data_reg;
         assign valid_out[gi]                 = lane_valid_reg;
      end
   endgenerate

   assign lane_ptr = lane_ptr_reg;
   assign err_sel  = err_sel_reg;

endmodule
